// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem reads and buffers returned words
// with their PC for decode. A redirect flushes the buffer and discards reads still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {HOLD, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];
    logic [31:0]   tag_q        [DEPTH];
    logic [31:0]   tag_d        [DEPTH];

    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          fifo_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every buffered, outstanding or doomed read holds one credit, so the FIFO can never overflow.
    always_comb begin
        credit_sum     = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q} + {1'b0, drop_cnt_q};
        imem_req_valid = (state_q != HOLD) && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
        imem_req_addr  = pc_q;
        id_valid       = (fifo_cnt_q != '0);
        id_instr       = id_valid ? fifo_instr_q[fifo_rd_q] : NOP;
        id_pc          = id_valid ? fifo_pc_q[fifo_rd_q] : '0;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
        rsp_keep       = imem_rsp_valid && !rsp_drop;
        fifo_pop       = id_valid && id_ready && !redirect_valid;
    end

    always_comb begin
        pc_d          = pc_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        tag_d         = tag_q;

        if (rsp_keep) begin
            fifo_instr_d[fifo_wr_q] = imem_rsp_data;
            fifo_pc_d[fifo_wr_q]    = tag_q[tag_rd_q];
            fifo_wr_d               = ptr_inc(fifo_wr_q);
            tag_rd_d                = ptr_inc(tag_rd_q);
        end
        if (fifo_pop)
            fifo_rd_d = ptr_inc(fifo_rd_q);
        if (req_fire) begin
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = ptr_inc(tag_wr_q);
            pc_d            = pc_q + 32'd4;
        end

        fifo_cnt_d    = fifo_cnt_q + CW'(rsp_keep) - CW'(fifo_pop);
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_keep);
        drop_cnt_d    = drop_cnt_q - CW'(imem_rsp_valid && (drop_cnt_q != '0));

        // Everything in flight becomes doomed; a response arriving now is the first casualty.
        if (redirect_valid) begin
            pc_d          = redirect_pc & ~32'h3;
            fifo_rd_d     = '0;
            fifo_wr_d     = '0;
            fifo_cnt_d    = '0;
            tag_rd_d      = '0;
            tag_wr_d      = '0;
            outstanding_d = '0;
            drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(imem_rsp_valid);
        end

        state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOLD;
            pc_q          <= RESET_PC;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
                tag_q[i]        <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
            tag_q         <= tag_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && !fifo_pop && (fifo_cnt_q == CW'(DEPTH))));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven reset/stream vectors, hand-written redirect and reset
// corner cases, then randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    // Second instance starting just below the top of the address space, memory latency 1.
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(32'h0000_0033), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(w_id_valid), .id_ready(1'b1),
        .id_instr(w_id_instr), .id_pc(w_id_pc)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_rsp_valid <= 1'b0;
        else        w_rsp_valid <= w_req_valid;
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct {
        bit rdy; bit idr;
        bit exp_req; logic [31:0] exp_addr; bit exp_idv; logic [31:0] exp_idpc;
    } vec_t;

    mem_req_t    mem_q[$];
    flight_t     m_flight[$];
    entry_t      m_fifo[$];
    logic [31:0] m_pc;
    bit          m_hold;
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] w_addrs[$];

    bit          obs_req_valid, obs_accept, obs_id_valid, obs_rsp;
    logic [31:0] obs_addr, obs_id_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Asserts reset mid-cycle, checks the outputs respond immediately, then releases it just
    // before a falling edge so the next applyStimulus call sees the idle cycle after reset.
    task automatic doReset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_id_instr", id_instr, NOP);
        checkOutput("rst_id_pc", id_pc, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_q.delete();
        m_flight.delete();
        m_fifo.delete();
        w_addrs.delete();
        m_pc   = RESET_PC;
        m_hold = 1'b1;
        cyc    = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance model and memory.
    task automatic applyStimulus(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
        bit      exp_req;
        bit      rsp;
        flight_t f;
        @(negedge clk);
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req = !m_hold && !redir && (m_fifo.size() + m_flight.size() < DEPTH);
        checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
        checkOutput("req_addr", imem_req_addr, m_pc);
        checkOutput("id_valid", 32'(id_valid), 32'(m_fifo.size() > 0));
        checkOutput("id_pc", id_pc, (m_fifo.size() > 0) ? m_fifo[0].pc : 32'd0);
        checkOutput("id_instr", id_instr, (m_fifo.size() > 0) ? m_fifo[0].instr : NOP);

        obs_req_valid = imem_req_valid;
        obs_accept    = imem_req_valid && rdy;
        obs_addr      = imem_req_addr;
        obs_id_valid  = id_valid;
        obs_id_pc     = id_pc;
        obs_rsp       = rsp;
        if (w_req_valid) w_addrs.push_back(w_req_addr);

        if (rsp) void'(mem_q.pop_front());
        if (imem_req_valid && rdy)
            mem_q.push_back('{imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});

        if (idr && !redir && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (rsp) begin
            checkOutput("rsp_tracked", 32'(m_flight.size() > 0), 32'd1);
            if (m_flight.size() > 0) begin
                f = m_flight.pop_front();
                if (!f.stale && !redir) m_fifo.push_back('{f.pc, mem_word(f.pc)});
            end
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            m_pc = rpc & ~32'h3;
        end else if (exp_req && rdy) begin
            m_flight.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        m_hold = 1'b0;
        cyc++;
    endtask

    initial begin
        vec_t        tbl[8];
        int          accepts;
        logic [31:0] expect_pc;
        bit          found;
        bit          first_seen;

        tbl[0] = '{1, 1, 0, 32'h00, 0, 32'h0};
        tbl[1] = '{1, 1, 1, 32'h00, 0, 32'h0};
        tbl[2] = '{1, 1, 1, 32'h04, 0, 32'h0};
        tbl[3] = '{1, 1, 0, 32'h08, 1, 32'h0};
        tbl[4] = '{1, 1, 1, 32'h08, 1, 32'h4};
        tbl[5] = '{1, 1, 1, 32'h0C, 0, 32'h0};
        tbl[6] = '{1, 1, 0, 32'h10, 1, 32'h8};
        tbl[7] = '{1, 1, 1, 32'h10, 1, 32'hC};

        // Streaming at latency 1 from reset
        lat_min = 1; lat_max = 1;
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].rdy, tbl[i].idr, 1'b0, 32'h0);
            checkOutput("t1_req_valid", 32'(obs_req_valid), 32'(tbl[i].exp_req));
            checkOutput("t1_req_addr", obs_addr, tbl[i].exp_addr);
            checkOutput("t1_id_valid", 32'(obs_id_valid), 32'(tbl[i].exp_idv));
            checkOutput("t1_id_pc", obs_id_pc, tbl[i].exp_idpc);
        end
        checkOutput("t5_wrap_count", 32'(w_addrs.size() >= 3), 32'd1);
        if (w_addrs.size() >= 3) begin
            checkOutput("t5_wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
            checkOutput("t5_wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
            checkOutput("t5_wrap_addr2", w_addrs[2], 32'h0000_0000);
        end

        // Decode stalled: only DEPTH requests, then resume without loss or duplication
        doReset();
        accepts = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            accepts += int'(obs_accept);
        end
        checkOutput("t2_accepts", accepts, DEPTH);
        checkOutput("t2_stalled", 32'(obs_req_valid), 32'd0);
        expect_pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_id_valid) begin
                checkOutput("t2_stream_pc", obs_id_pc, expect_pc);
                expect_pc = expect_pc + 32'd4;
            end
        end
        checkOutput("t2_resumed", 32'(expect_pc >= 32'd16), 32'd1);

        // Redirect with two reads outstanding at latency 3
        lat_min = 3; lat_max = 3;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_second_req", 32'(obs_accept), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_id_valid) begin
                found = 1'b1;
                checkOutput("t3_first_pc", obs_id_pc, 32'h100);
            end
        end
        checkOutput("t3_delivered", 32'(found), 32'd1);

        // Misaligned redirect coinciding with a pop and a response
        lat_min = 1; lat_max = 1;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h203);
        checkOutput("t4_pop_coincide", 32'(obs_id_valid), 32'd1);
        checkOutput("t4_rsp_coincide", 32'(obs_rsp), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_req_valid", 32'(obs_req_valid), 32'd1);
        checkOutput("t4_req_addr", obs_addr, 32'h200);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_id_valid) begin
                found = 1'b1;
                checkOutput("t4_first_pc", obs_id_pc, 32'h200);
            end
        end
        checkOutput("t4_delivered", 32'(found), 32'd1);

        // Reset with the FIFO full, then with two reads outstanding, then refetch
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_fifo_full", 32'(obs_id_valid && !obs_req_valid), 32'd1);
        lat_min = 3; lat_max = 3;
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        lat_min = 1; lat_max = 1;
        doReset();
        first_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_accept && !first_seen) begin
                first_seen = 1'b1;
                checkOutput("t6_refetch_addr", obs_addr, RESET_PC);
            end
        end
        checkOutput("t6_refetched", 32'(first_seen), 32'd1);

        // Randomized traffic against the reference model
        lat_min = 1; lat_max = 4;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            if (i == 1500) doReset();
            applyStimulus($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6,
                          $urandom_range(99, 0) < 6, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
